kgp_alu: RTL and testbench
==========================

Name: kgp_alu

Overview:
Registered integer ALU for the KGP-RISC execute stage. Performs add, two's-complement negate, logic, shift and 32x32 multiply operations selected by opcode/fcode. Results and the four status flags are captured on the clock edge one cycle after an accepted request and feed the writeback path and the flag register used by branch logic.

Parameters:
WIDTH, 32, datapath width. Only 32 is supported; shift amounts use the low 5 bits.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request strobe; operands and op codes are sampled when high
inp1  in  32  operand A (rs)
inp2  in  32  operand B (rt, or sign-extended immediate)
opcode  in  3  instruction class: 0 = register ALU ops, 1 = immediate ALU ops
fcode  in  4  function code within the class
out  out  32  result, or low word of the product
ext_out  out  32  high word of the product; 0 for non-multiply ops
carryFlag  out  1  carry / last bit shifted out
zFlag  out  1  result-is-zero
signFlag  out  1  result sign
overflowFlag  out  1  signed overflow
out_valid  out  1  high for exactly one cycle when out/ext_out/flags hold a new result

Behaviour:
- Reset (rst_n low, asynchronous): out, ext_out, all flags and out_valid are cleared to 0 immediately and stay 0 while reset is held.
- Latency is 1 cycle. If in_valid is high at rising edge N, the result is registered at N, and out_valid is high during cycle N+1.
- Back-to-back requests are accepted every cycle. There is no stall or backpressure.
- When in_valid is low, out_valid drops to 0 at the next edge. out, ext_out and the flags hold their last values.
- If reset is asserted mid-operation, the pending result is discarded.
- Operation decode for opcode 0:
  - fcode 0 add: inp1+inp2
  - fcode 1 comp: 0-inp2 (two's complement of inp2)
  - fcode 2 and: inp1&inp2
  - fcode 3 xor: inp1^inp2
  - fcode 4 shll: inp1 << inp2[4:0]
  - fcode 5 shrl: logical right shift of inp1 by inp2[4:0]
  - fcode 6 shllv: same operation as fcode 4
  - fcode 7 shrlv: same operation as fcode 5
  - fcode 8 shra: arithmetic right shift of inp1 by inp2[4:0]
  - fcode 9 shrav: same operation as fcode 8
  - fcode 10 mult: unsigned 64-bit product; {ext_out,out} = inp1*inp2
  - fcode 11 mults: signed 64-bit product
- Operation decode for opcode 1:
  - fcode 0 addi: inp1+inp2
  - fcode 1 compi: 0-inp2
- Any other opcode/fcode combination: out=0, ext_out=0, carryFlag=0, overflowFlag=0, signFlag=0, zFlag=1.
- ext_out is 0 for every non-multiply operation.
- zFlag:
  - multiply ops: 1 when the full 64-bit product is 0
  - all other ops: 1 when out == 0
- signFlag:
  - multiply ops: ext_out[31]
  - all other ops: out[31]
- carryFlag:
  - add/addi: bit 32 of the 33-bit sum
  - comp/compi: carry out of ~inp2+1, i.e. 1 only when inp2 == 0
  - shifts: the last bit shifted out; 0 when the shift amount is 0
  - logic and multiply ops: 0
- overflowFlag:
  - add/addi: set when the operands have the same sign and the result sign differs
  - comp/compi: set only when inp2 == 0x80000000
  - all other ops: 0
- Arithmetic wraps modulo 2^32; no saturation.
- A shift amount of 0 passes inp1 through unchanged.

Test Plan:
- Reset then arithmetic. Reset low while in_valid is high: all outputs 0. After release, addi 2+3 (op1 f0) -> out=5, z=0, c=0, out_valid high one cycle later. compi inp2=3 -> out=0xFFFFFFFD, s=1. add 0xFFFFFFFF+1 -> out=0, c=1, z=1. add 0x7FFFFFFF+1 -> overflowFlag=1.
- Logic. xor 2,3 -> 1. and 2,3 -> 2.
- Shifts. shll 2 by 3 -> 16. shrl 2 by 3 -> 0 with z=1 and c=0. shllv/shrlv give identical results. shrl 0x80000000 by 31 -> 1.
- Arithmetic shift. shra 1024 by 3 -> 128. shrav 0xFFFFFC00 (-1024) by 3 -> 0xFFFFFF80 with s=1.
- Multiply. mult 2*3 -> out=6, ext_out=0. mults 2*(-3) -> out=0xFFFFFFFA, ext_out=0xFFFFFFFF, s=1. mult 0xFFFFFFFF*0xFFFFFFFF -> ext_out=0xFFFFFFFE, out=1.
- Streaming and illegal codes. Issue 5 back-to-back ops: results appear in order, one per cycle. An illegal fcode (op1 f5) -> out=0, z=1. Dropping in_valid deasserts out_valid while out holds its value.

Source files
------------

// File: rtl/kgp_alu_if.sv
// rtl/kgp_alu_if.sv - request/result bundle between the execute stage and the ALU
interface kgp_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] inp1;
  logic [WIDTH-1:0] inp2;
  logic [2:0]       opcode;
  logic [3:0]       fcode;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] ext_out;
  logic             carryFlag;
  logic             zFlag;
  logic             signFlag;
  logic             overflowFlag;
  logic             out_valid;

  modport master (
    output in_valid, inp1, inp2, opcode, fcode,
    input  out, ext_out, carryFlag, zFlag, signFlag, overflowFlag, out_valid
  );

  modport slave (
    input  in_valid, inp1, inp2, opcode, fcode,
    output out, ext_out, carryFlag, zFlag, signFlag, overflowFlag, out_valid
  );
endinterface

// File: rtl/kgp_alu.sv
// rtl/kgp_alu.sv - registered KGP-RISC integer ALU with status flags, one-cycle latency
module kgp_alu #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst_n,
  kgp_alu_if.slave bus
);

  typedef enum logic [3:0] {
    K_ADD, K_COMP, K_AND, K_XOR, K_SHL, K_SHR, K_SRA, K_MULU, K_MULS, K_ILL
  } kind_e;

  kind_e              w_kind;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [4:0]         w_shamt;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_neg;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH:0]     w_shr;
  logic [WIDTH:0]     w_sra;
  logic [2*WIDTH-1:0] w_prod_u;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_res;
  logic [WIDTH-1:0]   w_ext;
  logic               w_c;
  logic               w_z;
  logic               w_s;
  logic               w_v;

  logic [WIDTH-1:0]   r_out;
  logic [WIDTH-1:0]   r_ext;
  logic               r_c;
  logic               r_z;
  logic               r_s;
  logic               r_v;
  logic               r_valid;

  assign w_a     = bus.inp1;
  assign w_b     = bus.inp2;
  assign w_shamt = w_b[4:0];

  always_comb begin
    w_kind = K_ILL;
    if (bus.opcode == 3'd0) begin
      case (bus.fcode)
        4'd0:        w_kind = K_ADD;
        4'd1:        w_kind = K_COMP;
        4'd2:        w_kind = K_AND;
        4'd3:        w_kind = K_XOR;
        4'd4, 4'd6:  w_kind = K_SHL;
        4'd5, 4'd7:  w_kind = K_SHR;
        4'd8, 4'd9:  w_kind = K_SRA;
        4'd10:       w_kind = K_MULU;
        4'd11:       w_kind = K_MULS;
        default:     w_kind = K_ILL;
      endcase
    end else if (bus.opcode == 3'd1) begin
      case (bus.fcode)
        4'd0:    w_kind = K_ADD;
        4'd1:    w_kind = K_COMP;
        default: w_kind = K_ILL;
      endcase
    end
  end

  // The extra bit in each shift result catches the last bit shifted out,
  // and stays 0 naturally when the shift amount is 0.
  assign w_sum    = {1'b0, w_a} + {1'b0, w_b};
  assign w_neg    = {1'b0, ~w_b} + {{WIDTH{1'b0}}, 1'b1};
  assign w_shl    = {1'b0, w_a} << w_shamt;
  assign w_shr    = {w_a, 1'b0} >> w_shamt;
  assign w_sra    = $signed({w_a, 1'b0}) >>> w_shamt;
  assign w_prod_u = {{WIDTH{1'b0}}, w_a} * {{WIDTH{1'b0}}, w_b};
  assign w_prod_s = $signed({{WIDTH{w_a[WIDTH-1]}}, w_a}) *
                    $signed({{WIDTH{w_b[WIDTH-1]}}, w_b});

  always_comb begin
    w_res = '0;
    w_ext = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (w_kind)
      K_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
      end
      K_COMP: begin
        w_res = w_neg[WIDTH-1:0];
        w_c   = w_neg[WIDTH];
        w_v   = (w_b == {1'b1, {(WIDTH-1){1'b0}}});
      end
      K_AND: w_res = w_a & w_b;
      K_XOR: w_res = w_a ^ w_b;
      K_SHL: begin
        w_res = w_shl[WIDTH-1:0];
        w_c   = w_shl[WIDTH];
      end
      K_SHR: begin
        w_res = w_shr[WIDTH:1];
        w_c   = w_shr[0];
      end
      K_SRA: begin
        w_res = w_sra[WIDTH:1];
        w_c   = w_sra[0];
      end
      K_MULU: {w_ext, w_res} = w_prod_u;
      K_MULS: {w_ext, w_res} = w_prod_s;
      default: ;
    endcase
  end

  always_comb begin
    w_z = (w_res == '0);
    w_s = w_res[WIDTH-1];
    if (w_kind == K_MULU || w_kind == K_MULS) begin
      w_z = (w_res == '0) && (w_ext == '0);
      w_s = w_ext[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out   <= '0;
      r_ext   <= '0;
      r_c     <= 1'b0;
      r_z     <= 1'b0;
      r_s     <= 1'b0;
      r_v     <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_out <= w_res;
        r_ext <= w_ext;
        r_c   <= w_c;
        r_z   <= w_z;
        r_s   <= w_s;
        r_v   <= w_v;
      end
    end
  end

  assign bus.out          = r_out;
  assign bus.ext_out      = r_ext;
  assign bus.carryFlag    = r_c;
  assign bus.zFlag        = r_z;
  assign bus.signFlag     = r_s;
  assign bus.overflowFlag = r_v;
  assign bus.out_valid    = r_valid;

endmodule

// File: tb/tb_kgp_alu.sv
// tb/tb_kgp_alu.sv - scoreboard bench for kgp_alu against an arithmetic reference model
module tb_kgp_alu;

  typedef struct {
    logic [31:0] res;
    logic [31:0] ext;
    logic        c;
    logic        z;
    logic        s;
    logic        v;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb_q[$];
  logic [31:0] last_out;

  kgp_alu_if #(.WIDTH(32)) bus ();

  kgp_alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2:0] op, input logic [3:0] f,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t            e;
    longint unsigned ua;
    longint unsigned ub;
    longint          sa;
    longint          sb;
    longint          ss;
    longint unsigned full;
    logic [63:0]     p;
    int              n;
    int              k;
    bit              mul;
    ua  = a;
    ub  = b;
    sa  = $signed(a);
    sb  = $signed(b);
    n   = int'(b[4:0]);
    mul = 0;
    e.res = 0; e.ext = 0; e.c = 0; e.v = 0; e.z = 0; e.s = 0;
    k = -1;
    if (op == 3'd0 && f <= 4'd11) k = int'(f);
    if (op == 3'd1 && f <= 4'd1)  k = int'(f);
    case (k)
      0: begin
        full  = ua + ub;
        e.res = full[31:0];
        e.c   = full[32];
        ss    = sa + sb;
        e.v   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      1: begin
        full  = 64'd0 - ub;
        e.res = full[31:0];
        e.c   = (b == 0);
        e.v   = (-sb > 64'sd2147483647);
      end
      2: e.res = a & b;
      3: e.res = a ^ b;
      4, 6: begin
        full  = ua << n;
        e.res = full[31:0];
        e.c   = (n != 0) ? full[32] : 1'b0;
      end
      5, 7, 8, 9: begin
        if (k >= 8) begin
          full = 64'(sa >>> n);
          e.res = full[31:0];
        end else begin
          full = ua >> n;
          e.res = full[31:0];
        end
        full = (n != 0) ? (ua >> (n - 1)) : 64'd0;
        e.c  = (n != 0) ? full[0] : 1'b0;
      end
      10: begin p = ua * ub; {e.ext, e.res} = p; mul = 1; end
      11: begin p = 64'(sa * sb); {e.ext, e.res} = p; mul = 1; end
      default: ;
    endcase
    if (mul) begin
      e.z = ({e.ext, e.res} == 64'd0);
      e.s = e.ext[31];
    end else begin
      e.z = (e.res == 0);
      e.s = e.res[31];
    end
    return e;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [3:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.fcode    = f;
    bus.inp1     = a;
    bus.inp2     = b;
    sb_q.push_back(model(op, f, a, b));
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.opcode   = 3'($urandom);
    bus.fcode    = 4'($urandom);
    bus.inp1     = $urandom;
    bus.inp2     = $urandom;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (bus.out !== 0 || bus.ext_out !== 0 || bus.carryFlag !== 0 || bus.zFlag !== 0 ||
        bus.signFlag !== 0 || bus.overflowFlag !== 0 || bus.out_valid !== 0) begin
      errors++;
      $display("FAIL %s: out=%h ext=%h c=%b z=%b s=%b v=%b vld=%b, required all zero",
               name, bus.out, bus.ext_out, bus.carryFlag, bus.zFlag, bus.signFlag,
               bus.overflowFlag, bus.out_valid);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: out_valid=1 out=%h, required no result", bus.out);
      end else begin
        e = sb_q.pop_front();
        if (bus.out !== e.res || bus.ext_out !== e.ext || bus.carryFlag !== e.c ||
            bus.zFlag !== e.z || bus.signFlag !== e.s || bus.overflowFlag !== e.v) begin
          errors++;
          $display("FAIL result: got out=%h ext=%h c=%b z=%b s=%b v=%b, required out=%h ext=%h c=%b z=%b s=%b v=%b",
                   bus.out, bus.ext_out, bus.carryFlag, bus.zFlag, bus.signFlag, bus.overflowFlag,
                   e.res, e.ext, e.c, e.z, e.s, e.v);
        end
        last_out = e.res;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  op;
    logic [3:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    int          wait_cycles;
    checks   = 0;
    errors   = 0;
    last_out = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.opcode   = 3'd1;
    bus.fcode    = 4'd0;
    bus.inp1     = 32'd2;
    bus.inp2     = 32'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_held");
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    @(posedge clk);
    #1;

    issue(3'd1, 4'd0, 32'd2, 32'd3);
    issue(3'd1, 4'd1, 32'd0, 32'd3);
    issue(3'd0, 4'd0, 32'hFFFF_FFFF, 32'd1);
    issue(3'd0, 4'd0, 32'h7FFF_FFFF, 32'd1);
    issue(3'd0, 4'd1, 32'd5, 32'd0);
    issue(3'd0, 4'd1, 32'd5, 32'h8000_0000);
    issue(3'd0, 4'd3, 32'd2, 32'd3);
    issue(3'd0, 4'd2, 32'd2, 32'd3);
    issue(3'd0, 4'd4, 32'd2, 32'd3);
    issue(3'd0, 4'd5, 32'd2, 32'd3);
    issue(3'd0, 4'd6, 32'd2, 32'd3);
    issue(3'd0, 4'd7, 32'd2, 32'd3);
    issue(3'd0, 4'd5, 32'h8000_0000, 32'd31);
    issue(3'd0, 4'd4, 32'hDEAD_BEEF, 32'd0);
    issue(3'd0, 4'd8, 32'd1024, 32'd3);
    issue(3'd0, 4'd9, 32'hFFFF_FC00, 32'd3);
    issue(3'd0, 4'd10, 32'd2, 32'd3);
    issue(3'd0, 4'd11, 32'd2, 32'hFFFF_FFFD);
    issue(3'd0, 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd1, 4'd5, 32'd7, 32'd9);
    issue(3'd0, 4'd12, 32'd7, 32'd9);
    issue(3'd2, 4'd0, 32'd7, 32'd9);
    issue(3'd0, 4'd3, 32'h1234_5678, 32'h0F0F_0F0F);

    idle();
    @(negedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out !== last_out) begin
      errors++;
      $display("FAIL hold_after_idle: out_valid=%b out=%h, required out_valid=0 out=%h",
               bus.out_valid, bus.out, last_out);
    end

    @(posedge clk);
    #1;
    issue(3'd0, 4'd0, 32'd100, 32'd200);
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    #1;
    check_all_zero("reset_mid_op");
    void'(sb_q.pop_front());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle();
      end else begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5, 6: begin op = 3'd0; f = 4'($urandom_range(0, 11)); end
          7, 8:                begin op = 3'd1; f = 4'($urandom_range(0, 1)); end
          default:             begin op = 3'($urandom); f = 4'($urandom); end
        endcase
        case ($urandom_range(0, 5))
          0:       a = 32'h8000_0000;
          1:       a = 32'hFFFF_FFFF;
          2:       a = 32'($urandom_range(0, 3));
          default: a = $urandom;
        endcase
        case ($urandom_range(0, 6))
          0:       b = 32'h8000_0000;
          1:       b = 32'h0;
          2:       b = 32'h7FFF_FFFF;
          default: b = $urandom;
        endcase
        issue(op, f, a, b);
      end
    end

    bus.in_valid = 1'b0;
    wait_cycles  = 0;
    while (sb_q.size() != 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results still pending, required 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
